// File: rtl/fb_mem_arbiter.sv
// Arbitrates the single synchronous-read RAM port between the VGA glyph fetch path and the CPU.
// Priority: pending VGA slot > starved CPU > live VGA request > CPU.
module fb_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vga_req,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  output logic [15:0]           vga_data,
  output logic                  vga_valid,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]           cpu_wdata,
  output logic [15:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic [CNT_WIDTH-1:0]  vga_defer_cnt
);

  localparam int unsigned StarveWidth = $clog2(STARVE_LIMIT + 2);
  localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    CIdle, CWait, CWr, CRd1, CRd2, CAck, CDone
  } cpu_state_e;

  cpu_state_e             cpu_state_q;
  logic                   pend_valid_q;
  logic [ADDR_WIDTH-1:0]  pend_addr_q;
  logic [StarveWidth-1:0] starve_q;
  logic                   vga_s1_q;
  logic                   vga_s2_q;

  logic cpu_elig;
  logic starved;
  logic grant_cpu;
  logic grant_vga;
  logic capture;

  always_comb begin
    cpu_elig  = cpu_req && ((cpu_state_q == CIdle) || (cpu_state_q == CWait));
    starved   = (starve_q >= StarveMax);
    grant_cpu = cpu_elig && !pend_valid_q && (starved || !vga_req);
    grant_vga = vga_req && !pend_valid_q && !grant_cpu;
    // A live request that loses always lands in the slot; the slot is drained the same cycle.
    capture   = vga_req && !grant_vga;
  end

  // Arbitration state, RAM request stage and VGA return pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      starve_q      <= '0;
      vga_defer_cnt <= '0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      vga_s1_q      <= 1'b0;
      vga_s2_q      <= 1'b0;
      vga_valid     <= 1'b0;
      vga_data      <= '0;
    end else begin
      pend_valid_q <= capture;
      if (capture) begin
        pend_addr_q <= vga_addr;
        if (vga_defer_cnt != '1) begin
          vga_defer_cnt <= vga_defer_cnt + CNT_WIDTH'(1);
        end
      end

      if (!cpu_req || grant_cpu) begin
        starve_q <= '0;
      end else if (!starved) begin
        starve_q <= starve_q + StarveWidth'(1);
      end

      mem_we <= grant_cpu && cpu_we;
      if (pend_valid_q) begin
        mem_addr <= pend_addr_q;
      end else if (grant_vga) begin
        mem_addr <= vga_addr;
      end else if (grant_cpu) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end

      vga_s1_q  <= pend_valid_q || grant_vga;
      vga_s2_q  <= vga_s1_q;
      vga_valid <= vga_s2_q;
      if (vga_s2_q) begin
        vga_data <= mem_rdata;
      end
    end
  end

  // CPU transaction FSM; one operation outstanding at a time.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_state_q <= CIdle;
      cpu_ack     <= 1'b0;
      cpu_rdata   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (cpu_state_q)
        CIdle, CWait: begin
          if (grant_cpu) begin
            if (cpu_we) begin
              cpu_state_q <= CWr;
              cpu_ack     <= 1'b1;
            end else begin
              cpu_state_q <= CRd1;
            end
          end else if (cpu_req) begin
            cpu_state_q <= CWait;
          end else begin
            cpu_state_q <= CIdle;
          end
        end
        CWr:  cpu_state_q <= CDone;
        CRd1: cpu_state_q <= CRd2;
        CRd2: begin
          cpu_state_q <= CAck;
          cpu_ack     <= 1'b1;
          cpu_rdata   <= mem_rdata;
        end
        CAck: cpu_state_q <= CDone;
        // Request is ignored here so a requester dropping req after ack is not regranted.
        CDone: cpu_state_q <= CIdle;
        default: cpu_state_q <= CIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Scoreboard bench for fb_mem_arbiter: a cycle-level transaction model predicts every RAM access,
// completion and deferral count; a negedge monitor compares against the DUT.
module tb_fb_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned SL = 4;
  localparam int unsigned CW = 8;
  localparam int DMAX = (1 << CW) - 1;

  logic          clk;
  logic          reset;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [15:0]   vga_data;
  logic          vga_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic [CW-1:0] vga_defer_cnt;

  fb_mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(SL),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .vga_req      (vga_req),
    .vga_addr     (vga_addr),
    .vga_data     (vga_data),
    .vga_valid    (vga_valid),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .vga_defer_cnt(vga_defer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM behind the arbiter: registered read, one cycle latency.
  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  logic last_req_q = 1'b0;
  always @(posedge clk) begin
    if (!reset) assert (!(vga_req && last_req_q)) else $error("vga_req pulses closer than 2 cycles");
    last_req_q <= vga_req;
  end

  typedef struct { int due; bit rd; logic [15:0] data; } resp_t;
  typedef struct { logic [15:0] addr; logic we; logic [15:0] wd; } mem_exp_t;
  resp_t    vq[$];
  resp_t    cq[$];
  mem_exp_t exp_mem [int];
  int       exp_defer [int];

  int checks = 0;
  int passes = 0;

  bit          m_pend = 0;
  logic [15:0] m_pend_addr = '0;
  int          m_starve = 0;
  int          m_defer = 0;
  int          cpu_free_at = 0;
  int          cpu_ack_cyc = 0;
  bit          cpu_active = 0;
  bit          last_v = 0;
  int          zero_chk_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp_v);
  endtask

  // Transaction-level reference: who gets the RAM this cycle and what each grant must produce.
  task automatic model_cycle(input int c);
    bit cpu_src, gv, gc, live_won;
    logic [15:0] ga;
    cpu_src = cpu_req && (c >= cpu_free_at);
    gv = 0;
    gc = 0;
    ga = vga_addr;
    if (m_pend) begin
      gv = 1;
      ga = m_pend_addr;
    end else if (cpu_src && m_starve >= int'(SL)) gc = 1;
    else if (vga_req) gv = 1;
    else if (cpu_src) gc = 1;
    live_won = vga_req && !m_pend && !gc;
    if (vga_req && !live_won) begin
      m_pend = 1;
      m_pend_addr = vga_addr;
      if (m_defer < DMAX) m_defer++;
    end else begin
      m_pend = 0;
    end
    if (!cpu_req || gc) m_starve = 0;
    else if (m_starve < int'(SL)) m_starve++;
    exp_defer[c + 1] = m_defer;
    if (gv) begin
      vq.push_back('{c + 3, 1'b1, ref_mem[ga]});
      exp_mem[c + 1] = '{ga, 1'b0, 16'h0};
    end
    if (gc) begin
      exp_mem[c + 1] = '{cpu_addr, cpu_we, cpu_wdata};
      if (cpu_we) begin
        ref_mem[cpu_addr] = cpu_wdata;
        cq.push_back('{c + 1, 1'b0, 16'h0});
        cpu_ack_cyc = c + 1;
        cpu_free_at = c + 3;
      end else begin
        cq.push_back('{c + 3, 1'b1, ref_mem[cpu_addr]});
        cpu_ack_cyc = c + 3;
        cpu_free_at = c + 5;
      end
    end
  endtask

  task automatic step(input bit v, input logic [15:0] va, input bit want, input bit we,
                      input logic [15:0] ca, input logic [15:0] wd);
    @(posedge clk);
    #1;
    reset = 1'b0;
    vga_req = v;
    vga_addr = va;
    last_v = v;
    if (cpu_active && cyc > cpu_ack_cyc) cpu_active = 0;
    if (!cpu_active) begin
      if (want) begin
        cpu_active = 1;
        cpu_ack_cyc = 32'h7fff_ffff;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = ca;
        cpu_wdata = wd;
      end else begin
        cpu_req = 1'b0;
      end
    end
    model_cycle(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 16'h0, 16'h0);
  endtask

  task automatic do_reset(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      vga_req = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      last_v = 0;
      r = cyc;
      while (vq.size() > 0 && vq[$].due > r) void'(vq.pop_back());
      while (cq.size() > 0 && cq[$].due > r) void'(cq.pop_back());
      exp_mem.delete(r + 1);
      exp_defer.delete(r + 1);
      m_pend = 0;
      m_starve = 0;
      m_defer = 0;
      cpu_free_at = 0;
      cpu_active = 0;
      zero_chk_cyc = r + 1;
    end
  endtask

  always @(negedge clk) begin
    if (cyc == zero_chk_cyc) begin
      check("reset_strobes", 32'({vga_valid, cpu_ack, mem_we}), 32'(0));
      check("reset_mem_addr", 32'(mem_addr), 32'(0));
      check("reset_rdata", {vga_data, cpu_rdata}, 32'(0));
      check("reset_wdata_cnt", 32'({mem_wdata, vga_defer_cnt}), 32'(0));
    end
    if (vq.size() > 0 && vq[0].due == cyc) begin
      check("vga_valid", 32'(vga_valid), 32'(1));
      if (vga_valid) check("vga_data", 32'(vga_data), 32'(vq[0].data));
      void'(vq.pop_front());
    end else begin
      check("vga_valid_idle", 32'(vga_valid), 32'(0));
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      check("cpu_ack", 32'(cpu_ack), 32'(1));
      if (cpu_ack && cq[0].rd) check("cpu_rdata", 32'(cpu_rdata), 32'(cq[0].data));
      void'(cq.pop_front());
    end else begin
      check("cpu_ack_idle", 32'(cpu_ack), 32'(0));
    end
    if (exp_mem.exists(cyc)) begin
      check("mem_we", 32'(mem_we), 32'(exp_mem[cyc].we));
      check("mem_addr", 32'(mem_addr), 32'(exp_mem[cyc].addr));
      if (exp_mem[cyc].we) check("mem_wdata", 32'(mem_wdata), 32'(exp_mem[cyc].wd));
      exp_mem.delete(cyc);
    end else begin
      check("mem_we_idle", 32'(mem_we), 32'(0));
    end
    if (exp_defer.exists(cyc)) begin
      check("vga_defer_cnt", 32'(vga_defer_cnt), 32'(exp_defer[cyc]));
      exp_defer.delete(cyc);
    end
  end

  initial begin
    bit v;
    reset = 1'b1;
    vga_req = 1'b0;
    vga_addr = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    for (int i = 0; i < 65536; i++) begin
      ram[i] = 16'(i * 7 + 3);
      ref_mem[i] = ram[i];
    end
    ram[16'h3000] = 16'h4142;
    ref_mem[16'h3000] = 16'h4142;

    do_reset(3);

    // Plain VGA fetch.
    step(1, 16'h3000, 0, 0, 16'h0, 16'h0);
    idle(4);
    // CPU write into the frame buffer, then VGA reads it back.
    step(0, 16'h0, 1, 1, 16'h3005, 16'hBEEF);
    idle(3);
    step(1, 16'h3005, 0, 0, 16'h0, 16'h0);
    idle(4);
    // Simultaneous VGA and CPU read with no starvation.
    step(1, 16'h3001, 1, 0, 16'h3002, 16'h0);
    idle(6);
    // CPU reads held back-to-back against VGA every other cycle.
    for (int i = 0; i < 30; i++) step(!last_v, 16'h3010 + 16'(i), 1, 0, 16'h3020 + 16'(i), 16'h0);
    idle(6);
    // Reset in the cycle after a CPU read grant.
    step(0, 16'h0, 1, 0, 16'h3003, 16'h0);
    do_reset(1);
    idle(6);

    // Randomized traffic over a small address window to provoke read-after-write hazards.
    for (int i = 0; i < 3000; i++) begin
      v = !last_v && ($urandom_range(0, 1) == 1);
      step(v, 16'h3000 | 16'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1, 16'h3000 | 16'($urandom_range(0, 15)), 16'($urandom));
    end

    // Drive deferrals until the counter saturates, then keep going to show it holds.
    for (int i = 0; i < 20000 && m_defer < DMAX; i++)
      step(!last_v, 16'h3000 | 16'($urandom_range(0, 15)), 1, 0,
           16'h3000 | 16'($urandom_range(0, 15)), 16'h0);
    step(0, 16'h0, 1, 0, 16'h3001, 16'h0);
    check("defer_saturated", 32'(vga_defer_cnt), 32'(DMAX));
    for (int i = 0; i < 200; i++)
      step(!last_v, 16'h3000 | 16'($urandom_range(0, 15)), 1, 0,
           16'h3000 | 16'($urandom_range(0, 15)), 16'h0);
    check("defer_no_wrap", 32'(vga_defer_cnt), 32'(DMAX));

    idle(10);
    check("vga_queue_drained", 32'(vq.size()), 32'(0));
    check("cpu_queue_drained", 32'(cq.size()), 32'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/fb_mem_arbiter.md
Name: fb_mem_arbiter

Overview:
- Shares the single synchronous-read frame-buffer/data RAM port between two requesters: the VGA glyph fetch path and the CPU load/store path.
- The VGA path has priority because it runs against a pixel deadline.
- A starvation counter guarantees CPU progress.
- A one-entry VGA pending slot ensures no VGA fetch is ever dropped.
- Sits between the VGA address generator, the CPU memory interface and the RAM.

Parameters:
ADDR_WIDTH, 16, width of all address buses
STARVE_LIMIT, 4, consecutive CPU-denied cycles after which CPU is force-granted
CNT_WIDTH, 16, width of VGA deferral statistics counter

Ports:
clk  in  1  system clock; all logic posedge
reset  in  1  synchronous, active-high
vga_req  in  1  single-cycle fetch request pulse
vga_addr  in  ADDR_WIDTH  fetch word address, valid with vga_req
vga_data  out  16  fetched word
vga_valid  out  1  one-cycle pulse, vga_data valid
cpu_req  in  1  level request; held until cpu_ack
cpu_we  in  1  1=write, 0=read; held with cpu_req
cpu_addr  in  ADDR_WIDTH  held with cpu_req
cpu_wdata  in  16  held with cpu_req
cpu_rdata  out  16  read data, valid with cpu_ack on reads
cpu_ack  out  1  one-cycle completion pulse
mem_addr  out  ADDR_WIDTH  registered RAM address
mem_we  out  1  registered RAM write enable
mem_wdata  out  16  registered RAM write data
mem_rdata  in  16  RAM read data, valid one cycle after mem_addr is presented
vga_defer_cnt  out  CNT_WIDTH  saturating count of VGA requests served from the pending slot

Behaviour:
- Reset: all outputs 0, pending slot empty, starve counter 0, CPU FSM C_IDLE. Reset mid-operation drops all in-flight ops; no vga_valid or cpu_ack is issued for them.
- Grant decision in each cycle N is made among three sources: the pending VGA slot, a live vga_req, and the CPU (cpu_req=1 and FSM in C_IDLE or C_WAIT).
- Priority order:
  - (1) pending slot;
  - (2) CPU if starve counter >= STARVE_LIMIT and pending slot empty;
  - (3) live vga_req;
  - (4) CPU.
- If a live vga_req loses in cycle N (to pending or forced CPU), it is captured into the pending slot. vga_defer_cnt increments, saturating at all-ones.
- The pending slot can never be full when a live vga_req loses to the pending entry. vga_req pulses must be at least 2 cycles apart, which is a source constraint. A bench assertion flags any violation.
- Starve counter:
  - increments each cycle the CPU is requesting but not granted;
  - clears on CPU grant or when cpu_req=0;
  - saturates at STARVE_LIMIT.
- Pipeline for a grant in cycle N:
  - N+1: mem_addr/mem_we/mem_wdata hold the granted op. mem_we=1 only for CPU writes; it is 0 in idle cycles, and mem_addr keeps its last value.
  - N+2: mem_rdata valid.
  - N+3: vga_valid=1 with vga_data, or cpu_ack=1 with cpu_rdata, both registered.
- VGA latency: 3 cycles from vga_req if granted directly, 4 if deferred one cycle.
- CPU write: cpu_ack pulses in cycle N+1, coincident with mem_we.
- CPU FSM:
  - C_IDLE: cpu_req=1 and granted goes to C_WR (write) or C_RD1 (read); cpu_req=1 and not granted goes to C_WAIT.
  - C_WAIT: on grant, goes to C_WR or C_RD1.
  - C_WR: cpu_ack=1, goes to C_DONE.
  - C_RD1: goes to C_RD2.
  - C_RD2: goes to C_ACK.
  - C_ACK: cpu_ack=1, goes to C_DONE.
  - C_DONE: goes to C_IDLE. cpu_req is ignored for this one cycle so a requester that drops req after ack is not regranted.
- The CPU is not eligible for grant outside C_IDLE/C_WAIT. One CPU op is outstanding at a time; VGA ops pipeline freely.
- vga_valid and cpu_ack never assert in the same cycle for the same grant slot. Each grant maps to exactly one completion.
- Address arithmetic is pass-through; no range checks. Writes anywhere, including the frame buffer at 0x3000, are permitted.

Test Plan:
- Reset, then vga_req with vga_addr=0x3000 and RAM[0x3000]=0x4142 → mem_addr=0x3000 at +1; vga_valid=1 with vga_data=0x4142 at +3; vga_defer_cnt=0.
- cpu_req write addr=0x3005, wdata=0xBEEF, no VGA traffic → mem_we=1, mem_addr=0x3005 next cycle; cpu_ack the same cycle; a subsequent VGA read of 0x3005 returns 0xBEEF.
- cpu_req read held while vga_req pulses every 2 cycles → CPU granted no later than STARVE_LIMIT+1 cycles after request; the concurrent vga_req is deferred; vga_defer_cnt=1; that VGA read completes at latency 4 with correct data.
- Simultaneous vga_req and CPU read with starve counter 0 → VGA granted first (valid at +3), CPU granted next cycle, cpu_ack at +4 with correct cpu_rdata.
- Reset asserted in the cycle after a CPU read grant → no cpu_ack, no vga_valid; all outputs 0 the following cycle; FSM back in C_IDLE.
- Force 2^16 deferrals (CNT_WIDTH=16) → vga_defer_cnt saturates at 0xFFFF without wrap.
